intr_ctrl: RTL

Machine-level interrupt controller between the interrupt sources (external line, machine timer, software bit) and the `core` trap logic. It owns the 64-bit `mtime`/`mtimecmp` timer and captures and masks the pending sources. It arbitrates them by fixed RISC-V priority and presents at most one request at a time to the core through a req/ack/done handshake. A small word-addressed config port gives the core access to its registers.

---
 rtl/intr_pkg.sv | 48 ++++
 rtl/intr_ctrl_mtimer.sv | 70 +++++++
 rtl/intr_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg
// Shared types and constants for the machine-level interrupt controller:
//   state_t      - request handshake FSM states
//   CAUSE_*      - mcause codes presented on intr_cause
//   ADDR_*       - config port word addresses
//   BIT_*        - positions of the sources inside the enable/pending words
//   cause_mask() - maps a latched cause code back to its enable/pending bit
// ---------------------------------------------------------------------------
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADDR_MIE         = 3'd4;
  localparam logic [2:0] ADDR_MIP         = 3'd5;
  localparam logic [2:0] ADDR_MSIP        = 3'd6;

  // Source positions within the {MEI, MTI, MSI} enable and pending words
  localparam int BIT_MSI = 0;
  localparam int BIT_MTI = 1;
  localparam int BIT_MEI = 2;

  // One-hot mask of the source that owns a given cause code
  function automatic logic [2:0] cause_mask(input logic [3:0] cause);
    logic [2:0] mask;
    mask = 3'b000;
    case (cause)
      CAUSE_MSI: mask[BIT_MSI] = 1'b1;
      CAUSE_MTI: mask[BIT_MTI] = 1'b1;
      CAUSE_MEI: mask[BIT_MEI] = 1'b1;
      default:   mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/intr_ctrl_mtimer.sv
// ---------------------------------------------------------------------------
// mtimer
// 64-bit machine timer: prescaler, mtime counter and mtimecmp compare.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wdata           - 32-bit write data shared by all four write strobes
//   we_mtime_lo/hi  - replace the low/high half of mtime
//   we_cmp_lo/hi    - replace the low/high half of mtimecmp
//   mtime, mtimecmp - current register values
//   timer_intr      - combinational unsigned compare mtime >= mtimecmp
// ---------------------------------------------------------------------------
module mtimer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic        we_mtime_lo,
  input  logic        we_mtime_hi,
  input  logic        we_cmp_lo,
  input  logic        we_cmp_hi,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_intr
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [15:0] presc;
  logic        tick;

  assign tick = (presc == PRESC_MAX);

  // Prescaler runs freely; mtime writes do not disturb its phase
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= 16'd0;
    end else if (tick) begin
      presc <= 16'd0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A software write to either half wins over the tick in that cycle, so the
  // written value is exactly what the next read returns
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= 64'd0;
    end else if (we_mtime_lo || we_mtime_hi) begin
      if (we_mtime_lo) mtime[31:0]  <= wdata;
      if (we_mtime_hi) mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Reset to all-ones so no timer interrupt is pending out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
    end else begin
      if (we_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (we_cmp_hi) mtimecmp[63:32] <= wdata;
    end
  end

  assign timer_intr = (mtime >= mtimecmp);

endmodule

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
// Machine-level interrupt controller. Captures MEI/MTI/MSI, masks them with
// the enable register, arbitrates MEI > MSI > MTI and hands one request at a
// time to the core via a req/ack/done handshake.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   ext_intr                   - external interrupt level (rising edge captured)
//   mie_global                 - mstatus.MIE; 0 blocks new requests
//   cfg_we/cfg_addr/cfg_wdata  - config register write port
//   cfg_rdata                  - combinational config read data
//   intr_req/intr_cause        - request and latched cause code to the core
//   intr_ack                   - core took the trap (one-cycle pulse)
//   intr_done                  - core executed mret (one-cycle pulse)
//   timer_intr                 - raw mtime >= mtimecmp compare
// ---------------------------------------------------------------------------
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_intr,
  input  logic        mie_global,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        intr_req,
  output logic [3:0]  intr_cause,
  input  logic        intr_ack,
  input  logic        intr_done,
  output logic        timer_intr
);

  state_t      state;
  state_t      state_next;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        ext_sync;
  logic        ext_prev;
  logic        ext_edge;
  logic        meip;
  logic        msip;
  logic [2:0]  mie_en;
  logic [2:0]  pending;
  logic [2:0]  eligible;
  logic [3:0]  win_cause;
  logic        take_req;
  logic        latched_live;
  logic        meip_clear;

  mtimer #(
    .TICK_DIV(TICK_DIV)
  ) u_mtimer (
    .clk        (clk),
    .rst        (rst),
    .wdata      (cfg_wdata),
    .we_mtime_lo(cfg_we && (cfg_addr == ADDR_MTIME_LO)),
    .we_mtime_hi(cfg_we && (cfg_addr == ADDR_MTIME_HI)),
    .we_cmp_lo  (cfg_we && (cfg_addr == ADDR_MTIMECMP_LO)),
    .we_cmp_hi  (cfg_we && (cfg_addr == ADDR_MTIMECMP_HI)),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .timer_intr (timer_intr)
  );

  // The external line is registered once, then compared with its previous
  // registered sample, so an edge sampled at clock k reaches MEIP at k+1
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync <= 1'b0;
      ext_prev <= 1'b0;
    end else begin
      ext_sync <= ext_intr;
      ext_prev <= ext_sync;
    end
  end

  assign ext_edge   = ext_sync & ~ext_prev;
  assign meip_clear = (state == REQ) && intr_ack && (intr_cause == CAUSE_MEI);

  // A fresh edge in the clearing cycle must not be lost, so set beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      meip <= 1'b0;
    end else if (ext_edge) begin
      meip <= 1'b1;
    end else if (meip_clear) begin
      meip <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_en <= 3'b000;
      msip   <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_MIE)  mie_en <= cfg_wdata[2:0];
      if (cfg_addr == ADDR_MSIP) msip   <= cfg_wdata[0];
    end
  end

  assign pending  = {meip, timer_intr, msip};
  assign eligible = pending & mie_en;

  // Fixed RISC-V priority: MEI, then MSI, then MTI
  always_comb begin
    win_cause = 4'd0;
    if (eligible[BIT_MEI])      win_cause = CAUSE_MEI;
    else if (eligible[BIT_MSI]) win_cause = CAUSE_MSI;
    else if (eligible[BIT_MTI]) win_cause = CAUSE_MTI;
  end

  assign take_req     = (state == IDLE) && mie_global && (eligible != 3'b000);
  assign latched_live = (eligible & cause_mask(intr_cause)) != 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ack arriving in the same cycle the source vanishes still counts: the
  // core has already committed to the trap
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_req) state_next = REQ;
      REQ: begin
        if (intr_ack)           state_next = SERVICE;
        else if (!latched_live) state_next = IDLE;
      end
      SERVICE: if (intr_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    intr_req = (state == REQ);
  end

  // Cause is captured only on entry to REQ and held until the next request
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_cause <= 4'd0;
    end else if (take_req) begin
      intr_cause <= win_cause;
    end
  end

  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      ADDR_MTIME_LO:    cfg_rdata = mtime[31:0];
      ADDR_MTIME_HI:    cfg_rdata = mtime[63:32];
      ADDR_MTIMECMP_LO: cfg_rdata = mtimecmp[31:0];
      ADDR_MTIMECMP_HI: cfg_rdata = mtimecmp[63:32];
      ADDR_MIE:         cfg_rdata = {29'd0, mie_en};
      ADDR_MIP:         cfg_rdata = {29'd0, pending};
      ADDR_MSIP:        cfg_rdata = {31'd0, msip};
      default:          cfg_rdata = 32'd0;
    endcase
  end

endmodule
